pc_control_unit: RTL
====================

PC_CONTROL_UNIT -- requirements
Module: pc_control_unit

Interface
REQ-001 Parameter ADDR_W, default 32, width of PC and all target buses.
REQ-002 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries, power of two, at least 2.
REQ-004 Ports, listed as name, direction, width, meaning:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- stall  in  1  hold PC and all state this cycle.
- jump  in  1  unconditional jump to jump_target.
- jump_reg  in  1  jump to reg_target.
- branch  in  1  conditional branch to branch_target.
- br_cond  in  3  condition: 000 EQ, 001 NE, 010 LT, 011 GE, 100 LTU, 101 GEU, 11x never-taken.
- zero_flag, neg_flag, carry_flag, ovf_flag  in  1 each  ALU flags; carry_flag=1 means no borrow.
- is_call  in  1  qualifies jump or jump_reg as a call.
- is_ret  in  1  qualifies jump_reg as a return.
- branch_target, jump_target, reg_target  in  ADDR_W each  candidate targets.
- pc  out  ADDR_W  current PC, registered.
- pc_plus4  out  ADDR_W  pc+4, combinational.
- pc_sel  out  2  00 sequential, 01 branch, 10 jump, 11 register/return.
- taken  out  1  non-sequential redirect selected this cycle.
- misalign  out  1  registered one-cycle pulse; the target just loaded had nonzero bits [1:0].
- ras_empty, ras_full  out  1 each  stack status.

Function
REQ-005 Condition: EQ=zero; NE=~zero; LT=neg^ovf; GE=~(neg^ovf); LTU=~carry; GEU=carry.
REQ-006 Selection priority: jump_reg (pc_sel 11), then jump (10), then branch with condition true (01), then sequential (00); taken=1 whenever pc_sel is not 00.
REQ-007 Return target when jump_reg and is_ret: RAS top if the stack is non-empty, else reg_target.
REQ-008 Next PC: selected target with bits [1:0] forced to 0; sequential next PC is pc+4, wrapping modulo 2^ADDR_W (max-4 -> 0).
REQ-009 PC updates every non-stalled cycle; with stall=1, pc, RAS and count hold, misalign drives 0, and pc_sel/taken still reflect inputs combinationally.
REQ-010 misalign=1 in the cycle after a non-stalled redirect whose raw target had nonzero bits [1:0]; otherwise 0.
REQ-011 pc_sel, taken and pc_plus4 are combinational from current inputs and pc; zero-cycle latency to the selection, one cycle to pc.

Reset
REQ-012 While rst=1 at a clock edge: pc=RESET_VECTOR, RAS count=0, misalign=0; rst overrides stall.
REQ-013 After reset: ras_empty=1, ras_full=0, pc_plus4=RESET_VECTOR+4.
REQ-014 Reset asserted mid-operation discards pending redirects and stack contents in the same edge.

Configuration
REQ-015 Macro PC_CONTROL_UNIT_RAS_EN compiles in the return-address stack.
REQ-016 With the macro defined: a non-stalled call (jump or jump_reg with is_call) pushes pc_plus4; a non-stalled return pops.
REQ-017 Push when full overwrites the oldest entry (circular) and count stays RAS_DEPTH; pop when empty is a no-op.
REQ-018 Call and return in the same cycle: pop-then-push, so the top is replaced and count is unchanged.
REQ-019 With the macro undefined: is_call and is_ret are ignored, returns use reg_target, ras_empty=1, ras_full=0, and no stack storage is synthesised.

Verification
REQ-020 rst=1 with RESET_VECTOR=0x100 -> pc=0x100; next cycle with no control inputs -> pc=0x104, pc_sel=00.
REQ-021 branch=1, br_cond=LT, neg=1, ovf=0, branch_target=0x40 -> pc_sel=01, taken=1, next pc=0x40; same with ovf=1 -> pc_sel=00.
REQ-022 jump=1 and branch-taken together, jump_target=0x200 -> pc_sel=10, next pc=0x200; with stall=1 pc holds.
REQ-023 pc=0xFFFFFFFC sequential -> pc=0x0; jump_target=0x203 -> pc=0x200 and misalign=1 for one cycle.
REQ-024 RAS_EN, depth 4: five calls from pc 0x10,0x20,0x30,0x40,0x50, then four returns -> pcs 0x54,0x44,0x34,0x24, then ras_empty=1; a fifth return goes to reg_target.
REQ-025 RAS_EN: call and return in the same cycle with top 0x34 at pc 0x80 -> next pc=0x34, new top=0x84, count unchanged.

Source files
------------

// File: rtl/pc_control_unit.sv
// pc_control_unit: program counter register, next-PC selection and branch condition
// evaluation, with an optional circular return-address stack.
// Define PC_CONTROL_UNIT_RAS_EN to compile in the return-address stack; without it
// is_call/is_ret are ignored and returns always use reg_target.
module pc_control_unit #(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int unsigned       RAS_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              jump,
    input  logic              jump_reg,
    input  logic              branch,
    input  logic [2:0]        br_cond,
    input  logic              zero_flag,
    input  logic              neg_flag,
    input  logic              carry_flag,
    input  logic              ovf_flag,
    input  logic              is_call,
    input  logic              is_ret,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [1:0]        pc_sel,
    output logic              taken,
    output logic              misalign,
    output logic              ras_empty,
    output logic              ras_full
);

    logic              cond_true;
    logic [ADDR_W-1:0] raw_target;
    logic [ADDR_W-1:0] next_pc;
    logic              misalign_d;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_hit;    // return is served from the stack

    assign pc_plus4 = pc + ADDR_W'(4);

    // Branch condition from ALU flags; carry_flag=1 means no borrow.
    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            3'b000:  cond_true = zero_flag;
            3'b001:  cond_true = ~zero_flag;
            3'b010:  cond_true = neg_flag ^ ovf_flag;
            3'b011:  cond_true = ~(neg_flag ^ ovf_flag);
            3'b100:  cond_true = ~carry_flag;
            3'b101:  cond_true = carry_flag;
            default: cond_true = 1'b0;
        endcase
    end

    // Priority select: register/return, jump, taken branch, sequential.
    always_comb begin
        pc_sel     = 2'b00;
        raw_target = pc_plus4;
        if (jump_reg) begin
            pc_sel     = 2'b11;
            raw_target = ras_hit ? ras_top : reg_target;
        end else if (jump) begin
            pc_sel     = 2'b10;
            raw_target = jump_target;
        end else if (branch && cond_true) begin
            pc_sel     = 2'b01;
            raw_target = branch_target;
        end
    end

    assign taken      = (pc_sel != 2'b00);
    assign next_pc    = taken ? {raw_target[ADDR_W-1:2], 2'b00} : pc_plus4;
    assign misalign_d = taken && (raw_target[1:0] != 2'b00);

    // PC register; reset wins over stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VECTOR;
        end else if (!stall) begin
            pc <= next_pc;
        end
    end

    // One-cycle misalign pulse after a non-stalled redirect to an unaligned target.
    always_ff @(posedge clk) begin
        if (rst || stall) begin
            misalign <= 1'b0;
        end else begin
            misalign <= misalign_d;
        end
    end

`ifdef PC_CONTROL_UNIT_RAS_EN
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PtrW-1:0]   top_q, top_d, ptr_pop;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_pop;
    logic              do_push, do_pop;

    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CntW'(RAS_DEPTH));
    assign ras_top   = ras_mem[top_q];
    assign ras_hit   = is_ret && !ras_empty;

    // Pop on an empty stack is dropped here so it cannot underflow the count.
    assign do_pop  = !stall && jump_reg && is_ret && !ras_empty;
    assign do_push = !stall && is_call && (jump || jump_reg);

    // Pop first, then push; a full push advances over the oldest entry.
    always_comb begin
        ptr_pop = do_pop ? top_q - 1'b1 : top_q;
        cnt_pop = do_pop ? cnt_q - 1'b1 : cnt_q;
        top_d   = ptr_pop;
        cnt_d   = cnt_pop;
        if (do_push) begin
            top_d = ptr_pop + 1'b1;
            if (cnt_pop != CntW'(RAS_DEPTH)) begin
                cnt_d = cnt_pop + 1'b1;
            end
        end
    end

    // Stack pointer and occupancy; reset empties the stack.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    // Stack storage; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            ras_mem[top_d] <= pc_plus4;
        end
    end
`else
    logic unused_ras;
    assign unused_ras = is_call ^ is_ret;
    assign ras_top    = '0;
    assign ras_hit    = 1'b0;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
`endif

endmodule
